// File: rtl/stop_lamp_overlay.sv
// STOP lamp overlay: maps the raster position onto glyph ROM coordinates and
// produces a two-stage pipelined lamp pixel gated by a frame-synchronised lamp FSM.
module stop_lamp_overlay #(
  parameter int unsigned X0           = 560,
  parameter int unsigned Y0           = 16,
  parameter int unsigned SCALE_SHIFT  = 0,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       de_in,
  input  logic       frame_start,
  input  logic       stop_flag,
  input  logic       blink_en,
  output logic [3:0] glyph_x,
  output logic [3:0] glyph_y,
  input  logic       pixell,
  input  logic       pixelc,
  input  logic       pixelr,
  output logic       lamp_pixel,
  output logic       de_out
);

  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + (48 << SCALE_SHIFT));
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + (16 << SCALE_SHIFT));

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    LIT  = 2'd1,
    DARK = 2'd2
  } lamp_state_t;

  lamp_state_t   state, state_d;
  logic [CW-1:0] blink_cnt, cnt_d;
  logic          lamp_lit;

  logic [9:0] dx, dy, col;
  logic [3:0] row;
  logic [1:0] seg_d, seg_q;
  logic       in_region;
  logic       reg1_valid, de1;
  logic       sel_bit;

  // Stage 0: explicit bounds keep dx/dy underflow from aliasing into the region.
  assign dx  = hcount - X_LO[9:0];
  assign dy  = vcount - Y_LO[9:0];
  assign col = dx >> SCALE_SHIFT;
  assign row = 4'(dy >> SCALE_SHIFT);

  assign in_region = de_in
                   & ({1'b0, hcount} >= X_LO) & ({1'b0, hcount} < X_HI)
                   & ({1'b0, vcount} >= Y_LO) & ({1'b0, vcount} < Y_HI);

  always_comb begin
    seg_d = 2'd2;
    if (col < 10'd16)      seg_d = 2'd0;
    else if (col < 10'd32) seg_d = 2'd1;
  end

  // Stage 1: ROM address and segment select.
  always_ff @(posedge clk) begin
    if (reset) begin
      glyph_x    <= '0;
      glyph_y    <= '0;
      seg_q      <= '0;
      reg1_valid <= 1'b0;
      de1        <= 1'b0;
    end else begin
      glyph_x    <= in_region ? col[3:0] : '0;
      glyph_y    <= in_region ? row      : '0;
      seg_q      <= in_region ? seg_d    : '0;
      reg1_valid <= in_region;
      de1        <= de_in;
    end
  end

  // Stage 2: pick the segment's ROM bit and gate it with the lamp state.
  always_comb begin
    sel_bit = 1'b0;
    case (seg_q)
      2'd0:    sel_bit = pixell;
      2'd1:    sel_bit = pixelc;
      2'd2:    sel_bit = pixelr;
      default: sel_bit = 1'b0;
    endcase
  end

  assign lamp_lit = (state == LIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      lamp_pixel <= 1'b0;
      de_out     <= 1'b0;
    end else begin
      lamp_pixel <= reg1_valid & lamp_lit & sel_bit;
      de_out     <= de1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OFF;
      blink_cnt <= '0;
    end else begin
      state     <= state_d;
      blink_cnt <= cnt_d;
    end
  end

  // Lamp state only advances on frame boundaries so a frame never tears.
  always_comb begin
    state_d = state;
    cnt_d   = blink_cnt;
    if (frame_start) begin
      case (state)
        OFF: begin
          if (stop_flag) begin
            state_d = LIT;
            cnt_d   = '0;
          end
        end
        LIT, DARK: begin
          if (!stop_flag) begin
            state_d = OFF;
            cnt_d   = '0;
          end else if (!blink_en) begin
            state_d = LIT;
            cnt_d   = '0;
          end else if (blink_cnt == CNT_LAST) begin
            cnt_d   = '0;
            state_d = (state == LIT) ? DARK : LIT;
          end else begin
            cnt_d   = blink_cnt + 1'b1;
          end
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stop_lamp_overlay.sv
// Directed bench for stop_lamp_overlay: an S=0 instance with a short blink
// period and an S=1 instance, both fed by a small bench-side glyph ROM.
module tb_stop_lamp_overlay;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hcount, vcount;
  logic       de_in, frame_start, stop_flag, blink_en;

  logic [3:0] glyph_x0, glyph_y0, glyph_x1, glyph_y1;
  logic       pixell0, pixelc0, pixelr0, pixell1, pixelc1, pixelr1;
  logic       lamp_pixel0, de_out0, lamp_pixel1, de_out1;

  // Glyph ROM: left segment only drawn on row 1; centre/right same on every row.
  logic [15:0] left_row1 = 16'h0FFC;
  logic [15:0] centre_row = 16'h00F0;
  logic [15:0] right_row = 16'h8001;
  logic        rom_force = 1'b0;

  assign pixell0 = rom_force | ((glyph_y0 == 4'd1) ? left_row1[glyph_x0] : 1'b0);
  assign pixelc0 = rom_force | centre_row[glyph_x0];
  assign pixelr0 = rom_force | right_row[glyph_x0];
  assign pixell1 = rom_force | ((glyph_y1 == 4'd1) ? left_row1[glyph_x1] : 1'b0);
  assign pixelc1 = rom_force | centre_row[glyph_x1];
  assign pixelr1 = rom_force | right_row[glyph_x1];

  stop_lamp_overlay #(
    .X0(560), .Y0(16), .SCALE_SHIFT(0), .BLINK_FRAMES(2)
  ) dut0 (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .de_in(de_in),
    .frame_start(frame_start), .stop_flag(stop_flag), .blink_en(blink_en),
    .glyph_x(glyph_x0), .glyph_y(glyph_y0),
    .pixell(pixell0), .pixelc(pixelc0), .pixelr(pixelr0),
    .lamp_pixel(lamp_pixel0), .de_out(de_out0)
  );

  stop_lamp_overlay #(
    .X0(560), .Y0(16), .SCALE_SHIFT(1), .BLINK_FRAMES(30)
  ) dut1 (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .de_in(de_in),
    .frame_start(frame_start), .stop_flag(stop_flag), .blink_en(blink_en),
    .glyph_x(glyph_x1), .glyph_y(glyph_y1),
    .pixell(pixell1), .pixelc(pixelc1), .pixelr(pixelr1),
    .lamp_pixel(lamp_pixel1), .de_out(de_out1)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Two-deep expectation pipe matching the 2-clk latency of dut0.
  logic       pv[2]  = '{1'b0, 1'b0};
  logic       pde[2] = '{1'b0, 1'b0};
  logic       pl[2]  = '{1'b0, 1'b0};
  logic       pck[2] = '{1'b0, 1'b0};
  logic [9:0] ph[2]  = '{10'd0, 10'd0};
  logic [9:0] pvc[2] = '{10'd0, 10'd0};

  task automatic cyc(input logic [9:0] h, input logic [9:0] v, input logic de,
                     input logic fs, input logic el, input logic ck);
    @(posedge clk); #1;
    if (pv[1]) begin
      check($sformatf("de_out h=%0d v=%0d", ph[1], pvc[1]), de_out0, pde[1]);
      if (pck[1])
        check($sformatf("lamp h=%0d v=%0d", ph[1], pvc[1]), lamp_pixel0, pl[1]);
    end
    pv[1] = pv[0]; pde[1] = pde[0]; pl[1] = pl[0]; pck[1] = pck[0];
    ph[1] = ph[0]; pvc[1] = pvc[0];
    pv[0] = 1'b1; pde[0] = de; pl[0] = el; pck[0] = ck; ph[0] = h; pvc[0] = v;
    hcount = h; vcount = v; de_in = de; frame_start = fs;
  endtask

  task automatic idle();
    cyc(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [8:1] blink_exp = 8'b0011_0011;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; hcount = '0; vcount = '0; de_in = 1'b0;
    frame_start = 1'b0; stop_flag = 1'b0; blink_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst glyph_x", glyph_x0, 4'd0);
    check("rst glyph_y", glyph_y0, 4'd0);
    check("rst lamp", lamp_pixel0, 1'b0);
    check("rst de_out", de_out0, 1'b0);
    reset = 1'b0;

    // Lamp lit, row-1 sweep at scale 1x.
    stop_flag = 1'b1;
    cyc(10'd0, 10'd17, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    for (int h = 556; h < 612; h++) begin
      logic el, ck;
      el = 1'b0; ck = 1'b0;
      case (h)
        559, 560, 561, 572, 573, 584, 596, 608: ck = 1'b1;
        562, 571, 580, 592, 607: begin ck = 1'b1; el = 1'b1; end
        default: ;
      endcase
      cyc(10'(h), 10'd17, 1'b1, 1'b0, el, ck);
    end
    idle(); idle(); idle();

    // Region boundaries; underflow or wrap would land on lit right-segment bits.
    cyc(10'd559, 10'd17, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(10'd608, 10'd17, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(10'd592, 10'd15, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(10'd592, 10'd32, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(10'd607, 10'd18, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(10'd562, 10'd17, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(); idle();

    // Scale 2x addressing on dut1.
    for (int h = 560; h < 564; h++) begin
      cyc(10'(h), 10'd18, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(10'(h), 10'd18, 1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("s1 glyph_x h=%0d", h), glyph_x1, (h < 562) ? 4'd0 : 4'd1);
      check($sformatf("s1 glyph_y h=%0d", h), glyph_y1, 4'd1);
    end
    cyc(10'd592, 10'd18, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(10'd592, 10'd18, 1'b1, 1'b0, 1'b0, 1'b0);
    check("s1 glyph_x h=592", glyph_x1, 4'd0);
    cyc(10'd600, 10'd18, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(10'd600, 10'd18, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(10'd600, 10'd18, 1'b1, 1'b0, 1'b0, 1'b0);
    check("s1 lamp h=600", lamp_pixel1, 1'b1);
    idle(); idle();

    // Not stopped: lamp dark everywhere even with every ROM bit set.
    stop_flag = 1'b0;
    cyc(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    rom_force = 1'b1;
    for (int v = 16; v < 32; v += 15)
      for (int h = 560; h < 608; h++)
        cyc(10'(h), 10'(v), 1'b1, 1'b0, 1'b0, 1'b1);
    idle(); idle();
    rom_force = 1'b0;

    // Blinking with two frames per phase.
    stop_flag = 1'b1; blink_en = 1'b1;
    for (int f = 1; f <= 8; f++) begin
      cyc(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(10'd562, 10'd17, 1'b1, 1'b0, blink_exp[f], 1'b1);
      idle(); idle();
    end
    cyc(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(10'd562, 10'd17, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(); idle();
    stop_flag = 1'b0;
    cyc(10'd562, 10'd17, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(); idle();
    cyc(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(10'd562, 10'd17, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(); idle();

    // Reset in the middle of a lit pixel run.
    stop_flag = 1'b1; blink_en = 1'b0;
    cyc(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(10'd562, 10'd17, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(10'd562, 10'd17, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(10'd562, 10'd17, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("pre-reset lamp", lamp_pixel0, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset lamp", lamp_pixel0, 1'b0);
    check("reset de_out", de_out0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("post-reset lamp off", lamp_pixel0, 1'b0);
    check("post-reset de_out", de_out0, 1'b1);
    pv[0] = 1'b0; pv[1] = 1'b0;
    de_in = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
